// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit.
//   - opcode constants (IR_Data[31:27])
//   - ALU operation codes driven on alu_instruction
//   - control-step state enumeration
//   - decode-class and control-word types shared by control_unit and ctrl_decode
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Undefined opcodes fall into C_NOP.
  typedef enum logic [2:0] {
    C_NOP, C_RTYPE, C_IMM, C_MEM, C_HALT
  } op_class_t;

  typedef struct packed {
    op_class_t  cls;
    logic       is_ld;   // C_MEM sub-kinds; neither set means ldi
    logic       is_st;
    logic [4:0] alu_op;  // op to drive in T4
  } decode_t;

  typedef struct packed {
    logic       pc_enable;
    logic       pc_increment_enable;
    logic       ir_enable;
    logic       y_enable;
    logic       z_enable;
    logic       mar_enable;
    logic       mdr_enable;
    logic       r_enable;
    logic       read;
    logic       write;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       ba_select;
    logic       pc_select;
    logic       z_lo_select;
    logic       mdr_select;
    logic       c_select;
    logic       r_select;
    logic [4:0] alu_instruction;
    logic       run;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier.
//   opcode : IR_Data[31:27]
//   dec    : instruction class (rtype / imm / mem / nop / halt), ld/st flags,
//            and the ALU op the execute step must drive.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec.cls    = C_NOP;
    dec.is_ld  = 1'b0;
    dec.is_st  = 1'b0;
    dec.alu_op = ALU_NONE;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec.cls    = C_RTYPE;
        dec.alu_op = opcode;
      end
      OP_ADDI: begin dec.cls = C_IMM; dec.alu_op = ALU_ADD; end
      OP_ANDI: begin dec.cls = C_IMM; dec.alu_op = ALU_AND; end
      OP_ORI:  begin dec.cls = C_IMM; dec.alu_op = ALU_OR;  end
      // all memory forms compute Rb + C for the address / value
      OP_LDI:  begin dec.cls = C_MEM; dec.alu_op = ALU_ADD; end
      OP_LD:   begin dec.cls = C_MEM; dec.is_ld = 1'b1; dec.alu_op = ALU_ADD; end
      OP_ST:   begin dec.cls = C_MEM; dec.is_st = 1'b1; dec.alu_op = ALU_ADD; end
      OP_HALT: dec.cls = C_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: fetch T0..T2, execute T3..T7, HALT.
//   clk, reset_n        : clock, async active-low reset (state -> S_RESET)
//   IR_Data[31:27]      : opcode of the instruction in IR
//   mem_ready           : only when MEM_WAIT_EN is defined; stretches the
//                         fetch read (T1) and the ld read (T6)
//   enables / strobes / selects / alu_instruction : datapath control
//   run                 : low only in HALT
// Optional feature macro: MEM_WAIT_EN.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
`ifdef MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  input  logic [31:0] IR_Data,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        ba_select,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic [4:0]  alu_instruction,
  output logic        run
);

`ifdef MEM_WAIT_EN
  logic mem_rdy;
  assign mem_rdy = mem_ready;
`else
  logic mem_rdy;
  assign mem_rdy = 1'b1;
`endif

  // Operand fields are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^IR_Data[26:0];

  state_t    state;
  decode_t   dec;
  ctrl_out_t o;

  ctrl_decode u_dec (
    .opcode (IR_Data[31:27]),
    .dec    (dec)
  );

  // State register. Reset parks in S_RESET so the first clock after
  // release always starts a fresh fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RESET;
    end else begin
      unique case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    if (mem_rdy) state <= S_T2;
        S_T2: begin
          case (dec.cls)
            C_HALT:  state <= S_HALT;
            C_NOP:   state <= S_T0;
            default: state <= S_T3;
          endcase
        end
        // Fall back to fetch if the class no longer names an executable op.
        S_T3:    state <= (dec.cls inside {C_RTYPE, C_IMM, C_MEM}) ? S_T4 : S_T0;
        S_T4:    state <= (dec.cls inside {C_RTYPE, C_IMM, C_MEM}) ? S_T5 : S_T0;
        S_T5:    state <= (dec.is_ld || dec.is_st) ? S_T6 : S_T0;
        S_T6:    if (!dec.is_ld || mem_rdy) state <= S_T7;
        S_T7:    state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Control word. Several steps differ per opcode (T3..T7) and IR is only
  // loaded at the end of T2, so outputs are decoded from the registered
  // state and the live opcode rather than pre-registered. Async reset
  // forces S_RESET, which decodes to the idle word immediately.
  always_comb begin
    o     = '0;
    o.run = 1'b1;
    case (state)
      S_T0: begin
        o.pc_select  = 1'b1;
        o.mar_enable = 1'b1;
      end
      S_T1: begin
        o.read                = 1'b1;
        o.mdr_enable          = 1'b1;
        o.pc_increment_enable = mem_rdy;  // once, on the completing cycle
      end
      S_T2: begin
        o.mdr_select = 1'b1;
        o.ir_enable  = 1'b1;
      end
      S_T3: begin
        if (dec.cls inside {C_RTYPE, C_IMM, C_MEM}) begin
          o.grb       = 1'b1;
          o.y_enable  = 1'b1;
          o.r_select  = (dec.cls != C_MEM);
          o.ba_select = (dec.cls == C_MEM);
        end
      end
      S_T4: begin
        if (dec.cls == C_RTYPE) begin
          o.grc             = 1'b1;
          o.r_select        = 1'b1;
          o.z_enable        = 1'b1;
          o.alu_instruction = dec.alu_op;
        end else if (dec.cls inside {C_IMM, C_MEM}) begin
          o.c_select        = 1'b1;
          o.z_enable        = 1'b1;
          o.alu_instruction = dec.alu_op;
        end
      end
      S_T5: begin
        if (dec.is_ld || dec.is_st) begin
          o.z_lo_select = 1'b1;
          o.mar_enable  = 1'b1;
        end else if (dec.cls inside {C_RTYPE, C_IMM, C_MEM}) begin
          o.z_lo_select = 1'b1;
          o.gra         = 1'b1;
          o.r_enable    = 1'b1;
        end
      end
      S_T6: begin
        if (dec.is_ld) begin
          o.read       = 1'b1;
          o.mdr_enable = 1'b1;
        end else if (dec.is_st) begin
          o.gra        = 1'b1;
          o.r_select   = 1'b1;
          o.mdr_enable = 1'b1;
        end
      end
      S_T7: begin
        if (dec.is_ld) begin
          o.mdr_select = 1'b1;
          o.gra        = 1'b1;
          o.r_enable   = 1'b1;
        end else if (dec.is_st) begin
          o.write = 1'b1;
        end
      end
      S_HALT:  o.run = 1'b0;
      default: ;
    endcase
  end

  assign PC_enable           = o.pc_enable;
  assign PC_increment_enable = o.pc_increment_enable;
  assign IR_enable           = o.ir_enable;
  assign Y_enable            = o.y_enable;
  assign Z_enable            = o.z_enable;
  assign MAR_enable          = o.mar_enable;
  assign MDR_enable          = o.mdr_enable;
  assign r_enable            = o.r_enable;
  assign read                = o.read;
  assign write               = o.write;
  assign Gra                 = o.gra;
  assign Grb                 = o.grb;
  assign Grc                 = o.grc;
  assign ba_select           = o.ba_select;
  assign PC_select           = o.pc_select;
  assign Z_LO_select         = o.z_lo_select;
  assign MDR_select          = o.mdr_select;
  assign c_select            = o.c_select;
  assign r_select            = o.r_select;
  assign alu_instruction     = o.alu_instruction;
  assign run                 = o.run;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit. A reference model expands each
// instruction into its per-cycle control words; the stimulus pushes them as
// the instruction runs and a negedge monitor pops and compares.
module tb_control_unit;

  typedef struct packed {
    logic pc_en, pc_inc, ir_en, y_en, z_en, mar_en, mdr_en, r_en;
    logic rd, wr, gra, grb, grc, ba;
    logic pc_sel, zlo, mdr_sel, c_sel, r_sel;
    logic [4:0] alu;
    logic run;
  } ov_t;

  typedef struct {
    ov_t v;
    int  id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] IR_Data = '0;
`ifdef MEM_WAIT_EN
  logic        mem_ready = 1'b1;
`endif

  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, Grc;
  logic ba_select, PC_select, Z_LO_select, MDR_select, c_select, r_select, run;
  logic [4:0] alu_instruction;

  ov_t act;
  assign act = {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
                MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, Grc,
                ba_select, PC_select, Z_LO_select, MDR_select, c_select,
                r_select, alu_instruction, run};

  exp_t q[$];
  ov_t  seq[$];
  bit   mr[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   instr_no = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk                 (clk),
    .reset_n             (reset_n),
`ifdef MEM_WAIT_EN
    .mem_ready           (mem_ready),
`endif
    .IR_Data             (IR_Data),
    .PC_enable           (PC_enable),
    .PC_increment_enable (PC_increment_enable),
    .IR_enable           (IR_enable),
    .Y_enable            (Y_enable),
    .Z_enable            (Z_enable),
    .MAR_enable          (MAR_enable),
    .MDR_enable          (MDR_enable),
    .r_enable            (r_enable),
    .read                (read),
    .write               (write),
    .Gra                 (Gra),
    .Grb                 (Grb),
    .Grc                 (Grc),
    .ba_select           (ba_select),
    .PC_select           (PC_select),
    .Z_LO_select         (Z_LO_select),
    .MDR_select          (MDR_select),
    .c_select            (c_select),
    .r_select            (r_select),
    .alu_instruction     (alu_instruction),
    .run                 (run)
  );

  function automatic void check(string name, int id, ov_t a, ov_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s instr %0d: got %h expected %h", name, id, a, e);
    end
  endfunction

  function automatic ov_t idle();
    ov_t v = '0;
    v.run = 1'b1;
    return v;
  endfunction

  function automatic void add_step(ov_t v, bit ready);
    seq.push_back(v);
    mr.push_back(ready);
  endfunction

  // Reference model: instruction -> list of control words, one per cycle.
  function automatic void build(logic [31:0] ir, int w1, int w6);
    logic [4:0] op;
    string kind;
    logic [4:0] aop;
    ov_t v;
    op = ir[31:27];
    seq.delete();
    mr.delete();
`ifndef MEM_WAIT_EN
    w1 = 0;
    w6 = 0;
`endif
    kind = "nop";
    aop  = 5'd0;
    case (op)
      5'd3:  begin kind = "alu"; aop = 5'd3; end
      5'd4:  begin kind = "alu"; aop = 5'd4; end
      5'd5:  begin kind = "alu"; aop = 5'd5; end
      5'd6:  begin kind = "alu"; aop = 5'd6; end
      5'd12: begin kind = "imm"; aop = 5'd3; end
      5'd13: begin kind = "imm"; aop = 5'd5; end
      5'd14: begin kind = "imm"; aop = 5'd6; end
      5'd1:  kind = "ldi";
      5'd0:  kind = "ld";
      5'd2:  kind = "st";
      5'd27: kind = "halt";
      default: kind = "nop";
    endcase

    v = idle(); v.pc_sel = 1; v.mar_en = 1; add_step(v, 1);
    for (int i = 0; i < w1; i++) begin
      v = idle(); v.rd = 1; v.mdr_en = 1; add_step(v, 0);
    end
    v = idle(); v.rd = 1; v.mdr_en = 1; v.pc_inc = 1; add_step(v, 1);
    v = idle(); v.mdr_sel = 1; v.ir_en = 1; add_step(v, 1);

    if (kind == "halt") begin
      for (int i = 0; i < 20; i++) begin
        v = idle(); v.run = 0; add_step(v, 1);
      end
    end else if (kind == "alu" || kind == "imm") begin
      v = idle(); v.grb = 1; v.r_sel = 1; v.y_en = 1; add_step(v, 1);
      v = idle(); v.z_en = 1; v.alu = aop;
      if (kind == "alu") begin v.grc = 1; v.r_sel = 1; end
      else v.c_sel = 1;
      add_step(v, 1);
      v = idle(); v.zlo = 1; v.gra = 1; v.r_en = 1; add_step(v, 1);
    end else if (kind != "nop") begin
      v = idle(); v.grb = 1; v.ba = 1; v.y_en = 1; add_step(v, 1);
      v = idle(); v.c_sel = 1; v.z_en = 1; v.alu = 5'd3; add_step(v, 1);
      if (kind == "ldi") begin
        v = idle(); v.zlo = 1; v.gra = 1; v.r_en = 1; add_step(v, 1);
      end else begin
        v = idle(); v.zlo = 1; v.mar_en = 1; add_step(v, 1);
        if (kind == "ld") begin
          for (int i = 0; i <= w6; i++) begin
            v = idle(); v.rd = 1; v.mdr_en = 1; add_step(v, i == w6);
          end
          v = idle(); v.mdr_sel = 1; v.gra = 1; v.r_en = 1; add_step(v, 1);
        end else begin
          v = idle(); v.gra = 1; v.r_sel = 1; v.mdr_en = 1; add_step(v, 1);
          v = idle(); v.wr = 1; add_step(v, 1);
        end
      end
    end
  endfunction

  // Runs one instruction from the edge that enters T0. limit>0 truncates.
  task automatic run_instr(input logic [31:0] ir, input int w1, input int w6,
                           input int limit);
    int n;
    exp_t e;
    build(ir, w1, w6);
    instr_no++;
    n = (limit > 0 && limit < seq.size()) ? limit : seq.size();
    @(posedge clk);
    #2;
    IR_Data = ir;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #2;
      end
      e.v  = seq[i];
      e.id = instr_no;
      q.push_back(e);
`ifdef MEM_WAIT_EN
      mem_ready = mr[i];
`endif
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("step", e.id, act, e.v);
    end
  end

  initial begin
    logic [4:0] op;
    #1;
    check("reset_idle", 0, act, idle());
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    check("post_release_idle", 0, act, idle());

    run_instr(32'h0900_0055, 0, 0, 0);   // ldi R2,0x55
    run_instr(32'h6197_FFFD, 0, 0, 0);   // addi R3,R2,-3
    run_instr(32'h0080_0010, 0, 0, 0);   // ld
    run_instr(32'h1234_5678 & 32'h17FF_FFFF | 32'h1000_0000, 0, 0, 0); // st
    run_instr(32'hD000_0000, 0, 0, 0);   // nop
    run_instr(32'hF800_0000, 0, 0, 0);   // undefined -> nop
    run_instr(32'h0080_0010, 3, 2, 0);   // ld with memory stalls

    // add, reset asserted during T4 with no clock edge
    run_instr({5'b00011, 27'h0123456}, 0, 0, 4);
    @(posedge clk);
    #1;
    check("add_t4", instr_no, act, seq[4]);
    #1;
    reset_n = 1'b0;
    #1;
    check("midT4_reset_idle", instr_no, act, idle());
    #1;
    reset_n = 1'b1;
    run_instr({5'b00100, 27'h7654321}, 0, 0, 0);  // sub, fresh from T0

    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr({op, 27'($urandom)}, $urandom_range(0, 2),
                $urandom_range(0, 2), 0);
    end

    // halt, hold 20 cycles, then reset pulse
    run_instr(32'hD800_0000, 0, 0, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("halt_reset_idle", instr_no, act, idle());
    #1;
    reset_n = 1'b1;
    run_instr({5'b00110, 27'h0000ABC}, 0, 0, 0);  // or after halt

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
